// File: rtl/apb_csr_pkg.sv
// Shared constants, address map and FSM state type for the APB CSR completer.
package apb_csr_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [ADDR_W-1:0] CSR_ID_ADDR       = 8'h00;
  localparam logic [ADDR_W-1:0] CSR_CTRL_ADDR     = 8'h01;
  localparam logic [ADDR_W-1:0] CSR_STATUS_ADDR   = 8'h02;
  localparam logic [ADDR_W-1:0] CSR_INT_STAT_ADDR = 8'h03;
  localparam logic [ADDR_W-1:0] CSR_INT_EN_ADDR   = 8'h04;
  localparam logic [ADDR_W-1:0] CSR_SCRATCH_BASE  = 8'h05;

  localparam logic [DATA_W-1:0] CTRL_RST     = 8'h00;
  localparam logic [DATA_W-1:0] STATUS_RST   = 8'h00;
  localparam logic [DATA_W-1:0] INT_STAT_RST = 8'h00;
  localparam logic [DATA_W-1:0] INT_EN_RST   = 8'h00;
  localparam logic [DATA_W-1:0] SCRATCH_RST  = 8'h00;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

endpackage

// File: rtl/csr_w1c_reg.sv
// 8-bit sticky status register: event bits set it, write-1-to-clear, set wins.
import apb_csr_pkg::*;

module csr_w1c_reg (
  input  logic              pclk,
  input  logic              prst,
  input  logic [DATA_W-1:0] set,
  input  logic [DATA_W-1:0] clr_mask,
  input  logic              we,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_r;
  logic [DATA_W-1:0] clr_eff;

  always_comb begin
    clr_eff = we ? clr_mask : '0;
  end

  always_ff @(posedge pclk) begin
    if (prst) q_r <= INT_STAT_RST;
    else      q_r <= (q_r & ~clr_eff) | set;
  end

  assign q = q_r;

endmodule

// File: rtl/apb_csr_slave.sv
// APB completer for a small CSR bank with programmable wait states.
// Optional error response on illegal accesses: define APB_CSR_SLVERR_EN.
import apb_csr_pkg::*;

module apb_csr_slave #(
  parameter int unsigned       WAIT_STATES = 0,
  parameter int unsigned       NUM_SCRATCH = 3,
  parameter logic [DATA_W-1:0] ID_VALUE    = 8'hA5
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [DATA_W-1:0] status_i,
  input  logic [DATA_W-1:0] event_i,
  output logic [DATA_W-1:0] ctrl_o,
  output logic              irq_o
);

  localparam int unsigned SCR_N = (NUM_SCRATCH == 0) ? 1 : NUM_SCRATCH;

  apb_slv_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              xfer_done;
  logic              wr_en;

  logic [DATA_W-1:0] ctrl_q;
  logic [DATA_W-1:0] status_q;
  logic [DATA_W-1:0] int_en_q;
  logic [DATA_W-1:0] int_stat;
  logic [DATA_W-1:0] scratch_q [SCR_N];
  logic              irq_q;

  logic              hit_id, hit_ctrl, hit_status, hit_int_stat, hit_int_en;
  logic [SCR_N-1:0]  hit_scr;
  logic [DATA_W-1:0] rd_mux;
  logic              slv_err;

  // State register
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q != '0) cnt_d   = cnt_q - 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign xfer_done = !prst && (state_q == ACCESS) && psel && penable && (cnt_q == '0);
  assign wr_en     = xfer_done && pwrite;

  // Address decode and read mux
  always_comb begin
    hit_id       = (paddr == CSR_ID_ADDR);
    hit_ctrl     = (paddr == CSR_CTRL_ADDR);
    hit_status   = (paddr == CSR_STATUS_ADDR);
    hit_int_stat = (paddr == CSR_INT_STAT_ADDR);
    hit_int_en   = (paddr == CSR_INT_EN_ADDR);
    hit_scr      = '0;
    rd_mux       = '0;
    for (int unsigned i = 0; i < SCR_N; i++) begin
      hit_scr[i] = (i < NUM_SCRATCH) && (paddr == CSR_SCRATCH_BASE + ADDR_W'(i));
      if (hit_scr[i]) rd_mux = scratch_q[i];
    end
    if (hit_id)       rd_mux = ID_VALUE;
    if (hit_ctrl)     rd_mux = ctrl_q;
    if (hit_status)   rd_mux = status_q;
    if (hit_int_stat) rd_mux = int_stat;
    if (hit_int_en)   rd_mux = int_en_q;
  end

`ifdef APB_CSR_SLVERR_EN
  logic mapped;
  logic illegal;

  always_comb begin
    mapped  = hit_id || hit_ctrl || hit_status || hit_int_stat || hit_int_en || (|hit_scr);
    illegal = !mapped || (pwrite && (hit_id || hit_status));
    slv_err = xfer_done && illegal;
  end
`else
  assign slv_err = 1'b0;
`endif

  // Register bank; writes to RO or unmapped addresses hit nothing
  always_ff @(posedge pclk) begin
    if (prst) begin
      ctrl_q   <= CTRL_RST;
      status_q <= STATUS_RST;
      int_en_q <= INT_EN_RST;
      irq_q    <= 1'b0;
      for (int unsigned i = 0; i < SCR_N; i++) scratch_q[i] <= SCRATCH_RST;
    end else begin
      status_q <= status_i;
      irq_q    <= |(int_stat & int_en_q);
      if (wr_en && hit_ctrl)   ctrl_q   <= pwdata;
      if (wr_en && hit_int_en) int_en_q <= pwdata;
      for (int unsigned i = 0; i < SCR_N; i++) begin
        if (wr_en && hit_scr[i]) scratch_q[i] <= pwdata;
      end
    end
  end

  csr_w1c_reg u_int_stat (
    .pclk     (pclk),
    .prst     (prst),
    .set      (event_i),
    .clr_mask (pwdata),
    .we       (wr_en && hit_int_stat),
    .q        (int_stat)
  );

  assign pready  = xfer_done;
  assign pslverr = slv_err;
  assign prdata  = (xfer_done && !slv_err) ? rd_mux : '0;
  assign ctrl_o  = ctrl_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_apb_csr_slave.sv
// Directed bench for apb_csr_slave: three instances with 0, 2 and 3 wait states.
module tb_apb_csr_slave;

`ifdef APB_CSR_SLVERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic            pclk = 1'b0;
  logic            prst;
  logic [2:0]      psel;
  logic            penable;
  logic            pwrite;
  logic [7:0]      paddr;
  logic [7:0]      pwdata;
  logic [7:0]      status_i;
  logic [7:0]      event_i;
  logic [2:0][7:0] prdata;
  logic [2:0]      pready;
  logic [2:0]      pslverr;
  logic [2:0][7:0] ctrl_o;
  logic [2:0]      irq_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_csr_slave #(.WAIT_STATES(0)) u_w0 (
    .pclk(pclk), .prst(prst), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0]), .status_i(status_i), .event_i(event_i),
    .ctrl_o(ctrl_o[0]), .irq_o(irq_o[0])
  );

  apb_csr_slave #(.WAIT_STATES(2)) u_w2 (
    .pclk(pclk), .prst(prst), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1]), .status_i(status_i), .event_i(event_i),
    .ctrl_o(ctrl_o[1]), .irq_o(irq_o[1])
  );

  apb_csr_slave #(.WAIT_STATES(3)) u_w3 (
    .pclk(pclk), .prst(prst), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[2]), .pready(pready[2]),
    .pslverr(pslverr[2]), .status_i(status_i), .event_i(event_i),
    .ctrl_o(ctrl_o[2]), .irq_o(irq_o[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One APB transfer on instance k; entered and left at posedge+1.
  // ev is driven on event_i during the completing cycle.
  task automatic apb_xfer(input int k, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input int exp_wait, input logic [7:0] ev,
                          output logic [7:0] rd, output logic err);
    int waits;
    psel[k] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge pclk); #1 penable = 1'b1;
    waits = 0;
    @(negedge pclk);
    while (!pready[k] && waits < 20) begin
      waits++;
      @(negedge pclk);
    end
    check($sformatf("wait_states[%0d]@%02h", k, addr), waits, exp_wait);
    rd  = prdata[k];
    err = pslverr[k];
    event_i = ev;
    @(posedge pclk); #1;
    event_i = '0; psel[k] = 1'b0; penable = 1'b0;
  endtask

  logic [7:0] rd;
  logic       err;
  int         rise;
  int         c0;

  initial begin
    prst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; status_i = 8'h9A; event_i = '0;
    repeat (3) @(posedge pclk);
    #1 prst = 1'b0;

    check("rst_pready",  pready[0],  1'b0);
    check("rst_prdata",  prdata[0],  8'h00);
    check("rst_pslverr", pslverr[0], 1'b0);
    check("rst_ctrl",    ctrl_o[0],  8'h00);
    check("rst_irq",     irq_o[0],   1'b0);

    // ID read, no wait states
    apb_xfer(0, 1'b0, 8'h00, 8'h00, 0, 8'h00, rd, err);
    check("id_rdata", rd, 8'hA5);
    check("id_err",   err, 1'b0);

    // CTRL write with two wait states
    check("ctrl_before", ctrl_o[1], 8'h00);
    apb_xfer(1, 1'b1, 8'h01, 8'h3C, 2, 8'h00, rd, err);
    check("ctrl_out", ctrl_o[1], 8'h3C);
    apb_xfer(1, 1'b0, 8'h01, 8'h00, 2, 8'h00, rd, err);
    check("ctrl_rdback", rd, 8'h3C);

    // Interrupt path
    event_i = 8'h04;
    @(posedge pclk); #1 event_i = '0;
    apb_xfer(0, 1'b1, 8'h04, 8'h04, 0, 8'h00, rd, err);
    check("irq_not_yet", irq_o[0], 1'b0);
    @(posedge pclk); #1;
    check("irq_set", irq_o[0], 1'b1);
    apb_xfer(0, 1'b1, 8'h03, 8'h04, 0, 8'h04, rd, err);
    @(posedge pclk); #1;
    check("irq_set_wins", irq_o[0], 1'b1);
    apb_xfer(0, 1'b0, 8'h03, 8'h00, 0, 8'h00, rd, err);
    check("int_stat_kept", rd, 8'h04);
    apb_xfer(0, 1'b1, 8'h03, 8'h04, 0, 8'h00, rd, err);
    @(posedge pclk); #1;
    check("irq_cleared", irq_o[0], 1'b0);
    apb_xfer(0, 1'b0, 8'h03, 8'h00, 0, 8'h00, rd, err);
    check("int_stat_clr", rd, 8'h00);

    // Illegal accesses
    apb_xfer(0, 1'b1, 8'h02, 8'h55, 0, 8'h00, rd, err);
    check("wr_status_err", err, EXP_ERR);
    apb_xfer(0, 1'b0, 8'h02, 8'h00, 0, 8'h00, rd, err);
    check("status_kept", rd, 8'h9A);
    check("status_rd_err", err, 1'b0);
    apb_xfer(0, 1'b0, 8'hF0, 8'h00, 0, 8'h00, rd, err);
    check("unmapped_rdata", rd, 8'h00);
    check("unmapped_err",   err, EXP_ERR);
    apb_xfer(0, 1'b1, 8'h00, 8'h12, 0, 8'h00, rd, err);
    check("wr_id_err", err, EXP_ERR);
    apb_xfer(0, 1'b0, 8'h00, 8'h00, 0, 8'h00, rd, err);
    check("id_kept", rd, 8'hA5);
    apb_xfer(0, 1'b0, 8'h08, 8'h00, 0, 8'h00, rd, err);
    check("past_scratch_err", err, EXP_ERR);
    apb_xfer(0, 1'b0, 8'h07, 8'h00, 0, 8'h00, rd, err);
    check("last_scratch_err", err, 1'b0);

    // Reset in the middle of a 3-wait-state write to scratch 0x05
    psel[2] = 1'b1; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'h77; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 prst = 1'b1;
    rise = 0;
    @(negedge pclk); if (pready[2]) rise++;
    @(posedge pclk); #1 prst = 1'b0;
    repeat (6) begin
      @(negedge pclk); if (pready[2]) rise++;
    end
    check("rst_no_ready", rise, 0);
    @(posedge pclk); #1 psel[2] = 1'b0; penable = 1'b0;
    check("rst_ctrl_cleared", ctrl_o[1], 8'h00);
    apb_xfer(2, 1'b0, 8'h05, 8'h00, 3, 8'h00, rd, err);
    check("rst_scratch", rd, 8'h00);

    // Back-to-back transfers, 4 cycles each at two wait states
    c0 = cyc;
    apb_xfer(1, 1'b1, 8'h05, 8'h11, 2, 8'h00, rd, err);
    apb_xfer(1, 1'b1, 8'h06, 8'h22, 2, 8'h00, rd, err);
    apb_xfer(1, 1'b0, 8'h05, 8'h00, 2, 8'h00, rd, err);
    check("b2b_rd05", rd, 8'h11);
    apb_xfer(1, 1'b0, 8'h06, 8'h00, 2, 8'h00, rd, err);
    check("b2b_rd06", rd, 8'h22);
    check("b2b_cycles", cyc - c0, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
